// File: rtl/hsv_axil_ram_responder.sv
// AXI4-Lite responder in front of a word-organised on-chip RAM.
// Optional macro HSV_AXIL_RAM_STROBE_EN enables per-byte write strobes.
module hsv_axil_ram_responder #(
    parameter int unsigned AddrWidth = 10,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000
) (
    input  logic        clk_core,
    input  logic        rst_core_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam int unsigned Depth = 1 << AddrWidth;

    typedef enum logic [1:0] {
        IDLE,
        READ_RESP,
        WRITE_RESP
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 prio_rd_q;
    logic                 rd_req;
    logic                 wr_req;
    logic                 rd_win;
    logic                 wr_win;
    logic                 rd_hs;
    logic                 wr_hs;
    logic                 idle;
    logic [1:0]           ar_chk;
    logic [1:0]           aw_chk;
    logic [AddrWidth-1:0] ar_idx;
    logic [AddrWidth-1:0] aw_idx;
    logic [1:0]           bresp_q;
    logic [1:0]           rresp_q;
    logic [31:0]          rdata_q;
    logic [31:0]          mem [Depth];

    // Misalignment takes precedence over an out-of-window address.
    function automatic logic [1:0] addr_check(input logic [31:0] a);
        if (a[1:0] != 2'b00) begin
            return AXI_RESP_SLVERR;
        end
        if (a[31:AddrWidth+2] != BaseAddr[31:AddrWidth+2]) begin
            return AXI_RESP_DECERR;
        end
        return AXI_RESP_OKAY;
    endfunction

    assign rd_req = arvalid;
    assign wr_req = awvalid & wvalid;
    assign rd_win = rd_req & (~wr_req | prio_rd_q);
    assign wr_win = wr_req & (~rd_req | ~prio_rd_q);
    assign rd_hs  = arready;
    assign wr_hs  = awready;
    assign ar_chk = addr_check(araddr);
    assign aw_chk = addr_check(awaddr);
    assign ar_idx = araddr[AddrWidth+1:2];
    assign aw_idx = awaddr[AddrWidth+1:2];

`ifndef HSV_AXIL_RAM_STROBE_EN
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
`endif

    // FSM state register.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rd_hs) begin
                    state_d = READ_RESP;
                end else if (wr_hs) begin
                    state_d = WRITE_RESP;
                end
            end
            READ_RESP: begin
                if (rready) begin
                    state_d = IDLE;
                end
            end
            WRITE_RESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; readys are gated by reset so none fire while it is held.
    always_comb begin
        idle    = (state_q == IDLE) & rst_core_n;
        arready = idle & rd_win;
        awready = idle & wr_win;
        wready  = idle & wr_win;
        bvalid  = (state_q == WRITE_RESP);
        rvalid  = (state_q == READ_RESP);
    end

    // Fairness flag: after any accepted transaction favour the other side.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            prio_rd_q <= 1'b1;
        end else if (rd_hs || wr_hs) begin
            prio_rd_q <= wr_hs;
        end
    end

    // Response registers, loaded at the address handshake and held until consumed.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            bresp_q <= AXI_RESP_OKAY;
            rresp_q <= AXI_RESP_OKAY;
            rdata_q <= '0;
        end else begin
            if (wr_hs) begin
                bresp_q <= aw_chk;
            end
            if (rd_hs) begin
                rresp_q <= ar_chk;
                rdata_q <= (ar_chk == AXI_RESP_OKAY) ? mem[ar_idx] : '0;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_core) begin
        if (wr_hs && (aw_chk == AXI_RESP_OKAY)) begin
`ifdef HSV_AXIL_RAM_STROBE_EN
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[aw_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
`else
            mem[aw_idx] <= wdata;
`endif
        end
    end

    assign bresp = bresp_q;
    assign rresp = rresp_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_hsv_axil_ram_responder.sv
// Directed self-checking bench for hsv_axil_ram_responder.
// Expected strobe result follows HSV_AXIL_RAM_STROBE_EN.
module tb_hsv_axil_ram_responder;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
`ifdef HSV_AXIL_RAM_STROBE_EN
    localparam logic [31:0] EXP_STRB = 32'hDE22_BE44;
`else
    localparam logic [31:0] EXP_STRB = 32'h1122_3344;
`endif

    logic        clk_core = 1'b0;
    logic        rst_core_n = 1'b0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_core = ~clk_core;

    hsv_axil_ram_responder dut (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rresp      (rresp)
    );

    // ok = handshake seen within budget and response valid exactly one cycle later
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output bit ok);
        ok = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s;
        bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_core);
            if (awready && wready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_core); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk_core);
        ok = ok && bvalid;
        resp = bresp;
        @(posedge clk_core); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [1:0] resp,
                            output logic [31:0] d, output bit ok);
        ok = 1'b0;
        arvalid = 1'b1; araddr = a; rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_core);
            if (arready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_core); #1;
        arvalid = 1'b0;
        @(negedge clk_core);
        ok = ok && rvalid;
        resp = rresp;
        d = rdata;
        @(posedge clk_core); #1;
    endtask

    task automatic test_reset();
        rst_core_n = 1'b0;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        n_cmp++;
        if ({arready, awready, wready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 000", {arready, awready, wready});
        end
        n_cmp++;
        if ({bvalid, rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_valid: got %b expected 00", {bvalid, rvalid});
        end
        n_cmp++;
        if ({bresp, rresp} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_resp: got %b expected 0000", {bresp, rresp});
        end
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        @(posedge clk_core); #1;
    endtask

    task automatic test_basic();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, r, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wr_latency: got 0 expected 1");
        end
        n_cmp++;
        if (r !== OKAY) begin
            n_err++;
            $display("FAIL wr_bresp: got %b expected %b", r, OKAY);
        end
        axi_read(32'h10, r, d, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rd_latency: got 0 expected 1");
        end
        n_cmp++;
        if (r !== OKAY) begin
            n_err++;
            $display("FAIL rd_rresp: got %b expected %b", r, OKAY);
        end
        n_cmp++;
        if (d !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL rd_data: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        axi_write(32'h10, 32'h1122_3344, 4'b0101, r, ok);
        n_cmp++;
        if (!ok || r !== OKAY) begin
            n_err++;
            $display("FAIL strb_wr: got ok=%0d resp=%b expected ok=1 resp=00", ok, r);
        end
        axi_read(32'h10, r, d, ok);
        n_cmp++;
        if (d !== EXP_STRB) begin
            n_err++;
            $display("FAIL strb_rd: got %h expected %h", d, EXP_STRB);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        axi_write(32'h0, 32'h0102_0304, 4'hF, r, ok);
        axi_read(32'h1000, r, d, ok);
        n_cmp++;
        if (!ok || r !== DECERR) begin
            n_err++;
            $display("FAIL rd_decerr: got ok=%0d resp=%b expected ok=1 resp=11", ok, r);
        end
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL rd_decerr_data: got %h expected 00000000", d);
        end
        axi_write(32'h1000, 32'hCAFE_F00D, 4'hF, r, ok);
        n_cmp++;
        if (!ok || r !== DECERR) begin
            n_err++;
            $display("FAIL wr_decerr: got ok=%0d resp=%b expected ok=1 resp=11", ok, r);
        end
        axi_read(32'h0, r, d, ok);
        n_cmp++;
        if (d !== 32'h0102_0304 || r !== OKAY) begin
            n_err++;
            $display("FAIL decerr_no_write: got %h/%b expected 01020304/00", d, r);
        end
        axi_read(32'h12, r, d, ok);
        n_cmp++;
        if (r !== SLVERR || d !== 32'h0) begin
            n_err++;
            $display("FAIL rd_slverr: got %b/%h expected 10/00000000", r, d);
        end
        axi_write(32'h11, 32'hFFFF_FFFF, 4'hF, r, ok);
        n_cmp++;
        if (r !== SLVERR) begin
            n_err++;
            $display("FAIL wr_slverr: got %b expected 10", r);
        end
        axi_read(32'h10, r, d, ok);
        n_cmp++;
        if (d !== EXP_STRB) begin
            n_err++;
            $display("FAIL slverr_no_write: got %h expected %h", d, EXP_STRB);
        end
        axi_write(32'hFFC, 32'hA5A5_0FF0, 4'hF, r, ok);
        axi_read(32'hFFC, r, d, ok);
        n_cmp++;
        if (d !== 32'hA5A5_0FF0 || r !== OKAY) begin
            n_err++;
            $display("FAIL top_word: got %h/%b expected a5a50ff0/00", d, r);
        end
        axi_read(32'hFFFF_FFFC, r, d, ok);
        n_cmp++;
        if (r !== DECERR) begin
            n_err++;
            $display("FAIL high_decerr: got %b expected 11", r);
        end
    endtask

    task automatic test_arbitration();
        int  gcyc[$];
        byte gkind[$];
        rst_core_n = 1'b0;
        arvalid = 1'b1; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h20;
        wdata = 32'h600D_F00D; wstrb = 4'hF;
        rready = 1'b1; bready = 1'b1;
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_core);
            n_cmp++;
            if (arready && awready) begin
                n_err++;
                $display("FAIL arb_both_ready: got 11 expected one-hot at cycle %0d", c);
            end
            if (arready) begin
                gcyc.push_back(c);
                gkind.push_back("R");
            end else if (awready) begin
                gcyc.push_back(c);
                gkind.push_back("W");
            end
        end
        n_cmp++;
        if (gkind.size() < 3) begin
            n_err++;
            $display("FAIL arb_count: got %0d expected >=3", gkind.size());
        end else if (gkind[0] != "R" || gkind[1] != "W" || gkind[2] != "R") begin
            n_err++;
            $display("FAIL arb_order: got %c%c%c expected RWR", gkind[0], gkind[1], gkind[2]);
        end else if (gcyc[0] != 0 || gcyc[1] != 2 || gcyc[2] != 4) begin
            n_err++;
            $display("FAIL arb_cadence: got %0d,%0d,%0d expected 0,2,4",
                     gcyc[0], gcyc[1], gcyc[2]);
        end
        @(posedge clk_core); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
    endtask

    task automatic test_aw_without_w();
        awvalid = 1'b1; awaddr = 32'h24; wdata = 32'h1357_9BDF; wstrb = 4'hF;
        wvalid = 1'b0; bready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_core);
            n_cmp++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                n_err++;
                $display("FAIL aw_alone: got %b%b expected 00 at cycle %0d",
                         awready, wready, c);
            end
        end
        @(posedge clk_core); #1;
        wvalid = 1'b1;
        @(negedge clk_core);
        n_cmp++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_err++;
            $display("FAIL aw_w_together: got %b%b expected 11", awready, wready);
        end
        @(posedge clk_core); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk_core);
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== OKAY) begin
            n_err++;
            $display("FAIL aw_w_bresp: got %b/%b expected 1/00", bvalid, bresp);
        end
        @(posedge clk_core); #1;
    endtask

    task automatic test_backpressure_reset();
        logic [1:0]  r;
        logic [31:0] d;
        bit          ok;
        bit          seen;
        axi_write(32'h40, 32'h5A5A_A5A5, 4'hF, r, ok);
        rready = 1'b0;
        arvalid = 1'b1; araddr = 32'h40;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_core);
            if (arready) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL bp_ar_handshake: got 0 expected 1");
        end
        @(posedge clk_core); #1;
        araddr = 32'h44;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_core);
            n_cmp++;
            if (rvalid !== 1'b1 || rdata !== 32'h5A5A_A5A5 || rresp !== OKAY) begin
                n_err++;
                $display("FAIL bp_hold: got %b/%h/%b expected 1/5a5aa5a5/00 at cycle %0d",
                         rvalid, rdata, rresp, c);
            end
            n_cmp++;
            if (arready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_arready: got %b expected 0 at cycle %0d", arready, c);
            end
        end
        #2;
        rst_core_n = 1'b0;
        #1;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_rvalid: got %b expected 0", rvalid);
        end
        @(posedge clk_core); #1;
        rst_core_n = 1'b1;
        @(negedge clk_core);
        n_cmp++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_to_idle: got arready=%b rvalid=%b expected 1/0",
                     arready, rvalid);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk_core); #1;
        axi_read(32'h40, r, d, ok);
        n_cmp++;
        if (d !== 32'h5A5A_A5A5 || r !== OKAY) begin
            n_err++;
            $display("FAIL ram_kept: got %h/%b expected 5a5aa5a5/00", d, r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_errors();
        test_arbitration();
        test_aw_without_w();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hsv_axil_ram_responder.md
Name: hsv_axil_ram_responder

Overview:
AXI4-Lite slave (responder) that fronts an on-chip word-organised RAM. It is the far end of the core's memory read/write path and is intended for the RAM/ROM region (address bits [31:30] == 0). It accepts one read or one write transaction at a time, arbitrates fairly between the read and write channels, and returns OKAY, SLVERR or DECERR responses using the package AXI response encodings. RAM contents are held in an internal array.

Parameters:
AddrWidth, 10, number of word-index bits; RAM depth is 2**AddrWidth words (default 4 KiB).
BaseAddr, 32'h0000_0000, byte base address; must be aligned to 4*2**AddrWidth.

Ports:
clk_core  in  1  core clock
rst_core_n  in  1  asynchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  32  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  32  write data
wstrb  in  4  write byte strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response (axi_resp_t)
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  32  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  read response (axi_resp_t)

Behaviour:
- Reset (asynchronous, active low): state=IDLE; awready=wready=arready=bvalid=rvalid=0; bresp=rresp=AXI_RESP_OKAY; rdata=0; priority flag=favour read. RAM contents are not reset.
- FSM states: IDLE, READ_RESP, WRITE_RESP.
- IDLE: arready=1 when arvalid is high and read is selected. awready=wready=1 only when awvalid&&wvalid are both high and write is selected; AW and W always handshake in the same cycle, never separately.
- Arbitration in IDLE: if only one side is requesting, it wins. If both are requesting, the side indicated by the priority flag wins. After each accepted transaction the flag toggles to favour the other side.
- Address checks, applied to the handshake address:
  - Unaligned (addr[1:0]!=0) -> SLVERR.
  - Else, out of range (addr[31:AddrWidth+2] != BaseAddr[31:AddrWidth+2]) -> DECERR.
  - Else -> OKAY.
- Write handshake cycle: if OKAY, RAM[addr[AddrWidth+1:2]] is updated per strobe (see Optional Feature) at that clock edge. On error, RAM is unchanged. Next cycle: bvalid=1 with bresp set, state=WRITE_RESP.
- Read handshake cycle: RAM is read synchronously. Next cycle: rvalid=1; rdata=RAM word if OKAY, else 0; rresp set; state=READ_RESP.
- Latency is 1 cycle from address handshake to response valid. Throughput is at most one transaction per 2 cycles with zero backpressure.
- WRITE_RESP / READ_RESP: bvalid/rvalid, resp and data are held stable until bready/rready is high. The cycle of that handshake clears valid and returns to IDLE. All ready outputs are 0 outside IDLE.
- Read-after-write to the same word returns the new data because the write completes before IDLE is re-entered.
- A mid-transaction reset drops any pending response. A write whose handshake edge has already occurred stays in RAM.
- AXI rule: valid outputs never depend combinationally on ready inputs. ready outputs may depend on valid inputs.

Optional Feature:
Macro HSV_AXIL_RAM_STROBE_EN.
- Defined: byte lane i is written only when wstrb[i]=1. wstrb=0 is a legal no-op write that returns OKAY.
- Undefined: wstrb is ignored and every OKAY write updates the full 32-bit word.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010 with strobe 0xF, bready=1 -> bvalid the cycle after handshake, bresp=OKAY. Read 0x10 -> rvalid one cycle after AR handshake, rdata=0xDEADBEEF, rresp=OKAY.
- Write 0x11223344 with wstrb=4'b0101 over 0xDEADBEEF at 0x10 -> readback 0xDE22BE44 with macro defined, 0x11223344 without.
- Read 0x0000_1000 with AddrWidth=10 -> rresp=DECERR, rdata=0. Write to the same address -> bresp=DECERR, no RAM word changes. Read 0x0000_0012 -> rresp=SLVERR.
- arvalid and awvalid+wvalid high together from reset, all held -> read served first, then write, then read (alternation); no cycle has both arready and awready high.
- awvalid=1 with wvalid=0 for 5 cycles -> awready stays 0; raise wvalid -> awready and wready rise together the same cycle.
- Hold rready=0 for 4 cycles after rvalid -> rvalid, rdata and rresp stable and arready=0 throughout. Assert rst_core_n=0 during READ_RESP -> rvalid=0 immediately (asynchronous) and FSM returns to IDLE.
